// File: rtl/fwd_datapath.sv
// fwd_datapath: D->X->M->W datapath slice with operand forwarding, load-use
// style hazard bubbles, global stall and D/X flush.
// Build option: define FWD_DATAPATH_BYPASS_EN to forward M/W results into the
// D-stage operand muxes; without it operands come only from the register file
// and any in-flight writer of a checked source stalls the D slot instead.
module fwd_datapath #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PC_INC = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            d_valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            d_ready_o,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_we_i,
  input  logic [XLEN-1:0] reg1_data_i,
  input  logic [XLEN-1:0] reg2_data_i,
  input  logic [XLEN-1:0] imm_signed_i,
  input  logic [XLEN-1:0] pc_val_d1_i,
  input  logic [XLEN-1:0] pc_val_d2_i,
  input  logic            x_op1_sel_i,
  input  logic            x_op2_sel_i,
  input  logic [2:0]      alu_sel_i,
  input  logic [XLEN-1:0] arith_out_i,
  input  logic [XLEN-1:0] logical_out_i,
  input  logic [XLEN-1:0] shift_out_i,
  output logic [XLEN-1:0] x_op1_o,
  output logic [XLEN-1:0] x_op2_o,
  output logic            x_valid_o,
  output logic [XLEN-1:0] m_alu_data_o,
  output logic [XLEN-1:0] w_data_o,
  output logic [4:0]      w_rd_addr_o,
  output logic            w_we_o
);

  localparam int unsigned RW = 5;

  // X stage
  logic            x_valid_q, x_valid_d;
  logic [RW-1:0]   x_rd_q, x_rd_d;
  logic            x_we_q, x_we_d;
  logic [XLEN-1:0] x_op1_q, x_op1_d;
  logic [XLEN-1:0] x_op2_q, x_op2_d;
  // M stage
  logic            m_valid_q, m_valid_d;
  logic [RW-1:0]   m_rd_q, m_rd_d;
  logic            m_we_q, m_we_d;
  logic [XLEN-1:0] m_data_q, m_data_d;
  // W stage; w_we_q already folds in valid and rd != 0
  logic [RW-1:0]   w_rd_q, w_rd_d;
  logic            w_we_q, w_we_d;
  logic [XLEN-1:0] w_data_q, w_data_d;

  logic            chk1, chk2;
  logic            x_hit, m_hit1, m_hit2, w_hit1, w_hit2;
  logic            hazard, accept, advance;
  logic [XLEN-1:0] src1, src2, op1, op2, alu_res;

  // True when a valid writer with a non-zero rd targets the given source
  function automatic logic src_hit(input logic          valid,
                                   input logic          we,
                                   input logic [RW-1:0] rd,
                                   input logic [RW-1:0] rs);
    return valid && we && (rd != '0) && (rd == rs);
  endfunction

  // Source matching, hazard detection and D-stage operand selection
  always_comb begin
    chk1   = !x_op1_sel_i;
    chk2   = !x_op2_sel_i;
    x_hit  = (chk1 && src_hit(x_valid_q, x_we_q, x_rd_q, rs1_addr_i)) ||
             (chk2 && src_hit(x_valid_q, x_we_q, x_rd_q, rs2_addr_i));
    m_hit1 = src_hit(m_valid_q, m_we_q, m_rd_q, rs1_addr_i);
    m_hit2 = src_hit(m_valid_q, m_we_q, m_rd_q, rs2_addr_i);
    w_hit1 = src_hit(w_we_q, 1'b1, w_rd_q, rs1_addr_i);
    w_hit2 = src_hit(w_we_q, 1'b1, w_rd_q, rs2_addr_i);
`ifdef FWD_DATAPATH_BYPASS_EN
    src1   = m_hit1 ? m_data_q : (w_hit1 ? w_data_q : reg1_data_i);
    src2   = m_hit2 ? m_data_q : (w_hit2 ? w_data_q : reg2_data_i);
    hazard = d_valid_i && x_hit;
`else
    src1   = reg1_data_i;
    src2   = reg2_data_i;
    hazard = d_valid_i && (x_hit ||
                           (chk1 && (m_hit1 || w_hit1)) ||
                           (chk2 && (m_hit2 || w_hit2)));
`endif
    op1     = x_op1_sel_i ? pc_val_d1_i  : src1;
    op2     = x_op2_sel_i ? imm_signed_i : src2;
    accept  = d_valid_i && !stall_i && !hazard && !flush_i;
    advance = flush_i || !stall_i;
  end

  // X-stage result select captured into M
  always_comb begin
    alu_res = '0;
    case (alu_sel_i)
      3'd0:    alu_res = arith_out_i;
      3'd1:    alu_res = logical_out_i;
      3'd2:    alu_res = shift_out_i;
      3'd3:    alu_res = x_op1_q;
      3'd4:    alu_res = pc_val_d2_i;
      3'd5:    alu_res = pc_val_d2_i + XLEN'(PC_INC);
      default: alu_res = '0;
    endcase
  end

  // Pipeline advance: hold on stall, bubble X on hazard/flush, kill M on flush
  always_comb begin
    x_valid_d = x_valid_q;
    x_rd_d    = x_rd_q;
    x_we_d    = x_we_q;
    x_op1_d   = x_op1_q;
    x_op2_d   = x_op2_q;
    m_valid_d = m_valid_q;
    m_rd_d    = m_rd_q;
    m_we_d    = m_we_q;
    m_data_d  = m_data_q;
    w_rd_d    = w_rd_q;
    w_we_d    = w_we_q;
    w_data_d  = w_data_q;
    if (advance) begin
      x_valid_d = accept;
      x_rd_d    = rd_addr_i;
      x_we_d    = rd_we_i;
      x_op1_d   = op1;
      x_op2_d   = op2;
      m_valid_d = x_valid_q && !flush_i;
      m_rd_d    = x_rd_q;
      m_we_d    = x_we_q;
      m_data_d  = alu_res;
      w_rd_d    = m_rd_q;
      w_we_d    = m_valid_q && m_we_q && (m_rd_q != '0);
      w_data_d  = m_data_q;
    end
  end

  // Stage registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_valid_q <= 1'b0;
      x_rd_q    <= '0;
      x_we_q    <= 1'b0;
      x_op1_q   <= '0;
      x_op2_q   <= '0;
      m_valid_q <= 1'b0;
      m_rd_q    <= '0;
      m_we_q    <= 1'b0;
      m_data_q  <= '0;
      w_rd_q    <= '0;
      w_we_q    <= 1'b0;
      w_data_q  <= '0;
    end else begin
      x_valid_q <= x_valid_d;
      x_rd_q    <= x_rd_d;
      x_we_q    <= x_we_d;
      x_op1_q   <= x_op1_d;
      x_op2_q   <= x_op2_d;
      m_valid_q <= m_valid_d;
      m_rd_q    <= m_rd_d;
      m_we_q    <= m_we_d;
      m_data_q  <= m_data_d;
      w_rd_q    <= w_rd_d;
      w_we_q    <= w_we_d;
      w_data_q  <= w_data_d;
    end
  end

  assign d_ready_o    = accept && !rst_i;
  assign x_valid_o    = x_valid_q;
  assign x_op1_o      = x_op1_q;
  assign x_op2_o      = x_op2_q;
  assign m_alu_data_o = m_data_q;
  assign w_data_o     = w_data_q;
  assign w_rd_addr_o  = w_rd_q;
  assign w_we_o       = w_we_q;

endmodule

// File: tb/tb_fwd_datapath.sv
// Directed table-driven bench for fwd_datapath; expectations follow the
// build option FWD_DATAPATH_BYPASS_EN.
module tb_fwd_datapath;

  localparam logic [31:0] PC1   = 32'h0000_0100;
  localparam logic [31:0] LOGIC = 32'hAAAA_0000;
  localparam logic [31:0] SHIFT = 32'h0000_BBBB;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        d_valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic        d_ready_o;
  logic [4:0]  rs1_addr_i = '0, rs2_addr_i = '0, rd_addr_i = '0;
  logic        rd_we_i = 1'b0;
  logic [31:0] reg1_data_i = '0, reg2_data_i = '0, imm_signed_i = '0;
  logic [31:0] pc_val_d1_i = PC1, pc_val_d2_i = '0;
  logic        x_op1_sel_i = 1'b0, x_op2_sel_i = 1'b0;
  logic [2:0]  alu_sel_i = '0;
  logic [31:0] arith_out_i = '0, logical_out_i = LOGIC, shift_out_i = SHIFT;
  logic [31:0] x_op1_o, x_op2_o, m_alu_data_o, w_data_o;
  logic        x_valid_o, w_we_o;
  logic [4:0]  w_rd_addr_o;

  int checks = 0;
  int errors = 0;

  fwd_datapath #(.XLEN(32), .PC_INC(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .d_valid_i(d_valid_i), .stall_i(stall_i),
    .flush_i(flush_i), .d_ready_o(d_ready_o), .rs1_addr_i(rs1_addr_i),
    .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .imm_signed_i(imm_signed_i), .pc_val_d1_i(pc_val_d1_i),
    .pc_val_d2_i(pc_val_d2_i), .x_op1_sel_i(x_op1_sel_i),
    .x_op2_sel_i(x_op2_sel_i), .alu_sel_i(alu_sel_i),
    .arith_out_i(arith_out_i), .logical_out_i(logical_out_i),
    .shift_out_i(shift_out_i), .x_op1_o(x_op1_o), .x_op2_o(x_op2_o),
    .x_valid_o(x_valid_o), .m_alu_data_o(m_alu_data_o), .w_data_o(w_data_o),
    .w_rd_addr_o(w_rd_addr_o), .w_we_o(w_we_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst, dv, stall, flush;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic [31:0] r1, r2, imm;
    logic        s1, s2;
    logic [2:0]  alu;
    logic [31:0] arith, pc2;
    logic        e_rdy, e_xv;
    logic [31:0] e_op1, e_op2, e_m, e_w;
    logic        e_wwe;
    logic [4:0]  e_wrd;
  } vec_t;

  vec_t vecs[$];

  // ctl = {rst, d_valid, stall, flush}; expectations are post-edge except rdy
  task automatic add(input logic [31:0] ctl, input logic [31:0] rs1, rs2, rd, we,
                     input logic [31:0] r1, r2, imm, s1, s2, alu, arith, pc2,
                     input logic [31:0] rdy, xv, op1, op2, m, w, wwe, wrd);
    vec_t v;
    v.rst = ctl[3]; v.dv = ctl[2]; v.stall = ctl[1]; v.flush = ctl[0];
    v.rs1 = rs1[4:0]; v.rs2 = rs2[4:0]; v.rd = rd[4:0]; v.we = we[0];
    v.r1 = r1; v.r2 = r2; v.imm = imm; v.s1 = s1[0]; v.s2 = s2[0];
    v.alu = alu[2:0]; v.arith = arith; v.pc2 = pc2;
    v.e_rdy = rdy[0]; v.e_xv = xv[0]; v.e_op1 = op1; v.e_op2 = op2;
    v.e_m = m; v.e_w = w; v.e_wwe = wwe[0]; v.e_wrd = wrd[4:0];
    vecs.push_back(v);
  endtask

  task automatic idle();
    add('b0000, 0,0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,0,0,0);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_i = v.rst; d_valid_i = v.dv; stall_i = v.stall; flush_i = v.flush;
    rs1_addr_i = v.rs1; rs2_addr_i = v.rs2; rd_addr_i = v.rd; rd_we_i = v.we;
    reg1_data_i = v.r1; reg2_data_i = v.r2; imm_signed_i = v.imm;
    x_op1_sel_i = v.s1; x_op2_sel_i = v.s2; alu_sel_i = v.alu;
    arith_out_i = v.arith; pc_val_d2_i = v.pc2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset overrides stall and flush
    add('b1111, 0,0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,0,0,0);
    // r1 <- 5, then r2 <- r1 + 3
    add('b0100, 0,0,1,1, 0,0,5, 0,1, 0,0,0, 1,1,0,5,0,0,0,0);
    add('b0100, 1,0,2,1, 0,0,3, 0,1, 0,5,0, 0,0,0,3,5,0,0,0);
`ifdef FWD_DATAPATH_BYPASS_EN
    add('b0100, 1,0,2,1, 0,0,3, 0,1, 0,0,0, 1,1,5,3,0,5,1,1);
    add('b0000, 0,0,0,0, 0,0,0, 0,0, 0,8,0, 0,0,0,0,8,0,0,2);
    add('b0000, 0,0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,8,1,2);
`else
    add('b0100, 1,0,2,1, 0,0,3, 0,1, 0,0,0, 0,0,0,3,0,5,1,1);
    add('b0100, 1,0,2,1, 0,0,3, 0,1, 0,0,0, 0,0,0,3,0,0,0,2);
    add('b0100, 1,0,2,1, 5,0,3, 0,1, 0,0,0, 1,1,5,3,0,0,0,2);
    add('b0000, 0,0,0,0, 0,0,0, 0,0, 0,8,0, 0,0,0,0,8,0,0,2);
    add('b0000, 0,0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,8,1,2);
`endif
    idle();
    // writer r3 = 0x10, two fillers, reader of r3 (reg file shows 0xDEAD)
    add('b0100, 0,0,3,1, 0,0,'h10, 0,1, 0,0,0, 1,1,0,'h10,0,0,0,0);
    add('b0100, 0,0,0,0, 0,0,7, 0,1, 0,'h10,0, 1,1,0,7,'h10,0,0,0);
    add('b0100, 0,0,0,0, 0,0,9, 0,1, 1,0,0, 1,1,0,9,'hAAAA0000,'h10,1,3);
`ifdef FWD_DATAPATH_BYPASS_EN
    add('b0100, 3,0,4,1, 'hDEAD,0,1, 0,1, 2,0,0, 1,1,'h10,1,'hBBBB,'hAAAA0000,0,0);
    add('b0000, 0,0,0,0, 0,0,0, 0,0, 3,0,0, 0,0,0,0,'h10,'hBBBB,0,0);
    add('b0000, 0,0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,'h10,1,4);
`else
    add('b0100, 3,0,4,1, 'hDEAD,0,1, 0,1, 2,0,0, 0,0,'hDEAD,1,'hBBBB,'hAAAA0000,0,0);
    add('b0100, 3,0,4,1, 'h10,0,1, 0,1, 0,0,0, 1,1,'h10,1,0,'hBBBB,0,0);
    add('b0000, 0,0,0,0, 0,0,0, 0,0, 3,0,0, 0,0,0,0,'h10,0,0,4);
    add('b0000, 0,0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,'h10,1,4);
`endif
    idle();
    // rd = 0 writer of 0x55, r0 readers, unchecked sources
    add('b0100, 0,0,0,1, 0,0,'h55, 0,1, 0,0,0, 1,1,0,'h55,0,0,0,0);
    add('b0100, 0,0,5,1, 0,0,2, 0,1, 0,'h55,0, 1,1,0,2,'h55,0,0,0);
    add('b0100, 0,5,6,1, 0,0,4, 0,1, 0,'h77,0, 1,1,0,4,'h77,'h55,0,0);
    add('b0100, 6,7,7,0, 'h1234,'h2222,0, 1,0, 4,0,'h200, 1,1,'h100,'h2222,'h200,'h77,1,5);
    // three stall cycles, then flush with stall
    for (int i = 0; i < 3; i++)
      add('b0110, 0,0,8,1, 0,0,'h33, 0,1, 0,'h99,0, 0,1,'h100,'h2222,'h200,'h77,1,5);
    add('b0111, 0,0,8,1, 0,0,'h33, 0,1, 0,'h99,0, 0,0,0,'h33,'h99,'h200,1,6);
    // PC + INC wrap and non-wrap, zero select, mid-stream reset
    add('b0000, 0,0,0,0, 0,0,0, 0,0, 5,0,'hFFFFFFFC, 0,0,0,0,0,'h99,0,7);
    add('b0000, 0,0,0,0, 0,0,0, 0,0, 5,0,'h1000, 0,0,0,0,'h1004,0,0,8);
    add('b0100, 0,0,9,1, 0,0,'h44, 0,1, 7,'hFF,0, 1,1,0,'h44,0,'h1004,0,0);
    add('b1111, 0,0,2,1, 0,0,'h66, 0,1, 0,'h5A,0, 0,0,0,0,0,0,0,0);
    add('b0100, 0,0,1,1, 0,0,'h11, 0,1, 0,0,0, 1,1,0,'h11,0,0,0,0);

    foreach (vecs[i]) begin
      @(negedge clk_i);
      drive(vecs[i]);
      #1;
      chk("d_ready", i, 32'(d_ready_o), 32'(vecs[i].e_rdy));
      @(posedge clk_i);
      #1;
      chk("x_valid", i, 32'(x_valid_o), 32'(vecs[i].e_xv));
      chk("x_op1", i, x_op1_o, vecs[i].e_op1);
      chk("x_op2", i, x_op2_o, vecs[i].e_op2);
      chk("m_alu_data", i, m_alu_data_o, vecs[i].e_m);
      chk("w_data", i, w_data_o, vecs[i].e_w);
      chk("w_we", i, 32'(w_we_o), 32'(vecs[i].e_wwe));
      chk("w_rd_addr", i, 32'(w_rd_addr_o), 32'(vecs[i].e_wrd));
    end

    // Hand sequence: accept-to-writeback latency with a bounded wait
    @(negedge clk_i);
    rst_i = 1'b1; d_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0; d_valid_i = 1'b1; rs1_addr_i = '0; rs2_addr_i = '0;
    rd_addr_i = 5'd9; rd_we_i = 1'b1; x_op1_sel_i = 1'b0; x_op2_sel_i = 1'b1;
    imm_signed_i = 32'h7; alu_sel_i = 3'd0; arith_out_i = 32'h1234;
    #1;
    chk("lat_ready", 100, 32'(d_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    d_valid_i = 1'b0;
    n = 1;
    while (!w_we_o && n < 10) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("lat_cycles", 100, 32'(n), 32'd3);
    chk("lat_w_data", 100, w_data_o, 32'h1234);
    chk("lat_w_rd", 100, 32'(w_rd_addr_o), 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_datapath.md
FWD_DATAPATH -- requirements
Module: fwd_datapath

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the width of every data port and register.
REQ-002 Parameter PC_INC, default 4, SHALL set the increment added for the PC+INC ALU select.
REQ-003 clk_i  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 d_valid_i  in  1  D-stage slot holds a valid instruction.
REQ-006 stall_i  in  1  global freeze request.
REQ-007 flush_i  in  1  kill the D and X stages.
REQ-008 d_ready_o  out  1  D instruction accepted into X this cycle.
REQ-009 rs1_addr_i / rs2_addr_i  in  5 each  D-stage source register indices.
REQ-010 rd_addr_i  in  5  D-stage destination index.
REQ-011 rd_we_i  in  1  D-stage instruction writes rd.
REQ-012 reg1_data_i / reg2_data_i  in  XLEN each  register-file read data.
REQ-013 imm_signed_i  in  XLEN  D-stage sign-extended immediate.
REQ-014 pc_val_d1_i / pc_val_d2_i  in  XLEN each  PC of the D / X instruction.
REQ-015 x_op1_sel_i  in  1  0 = register operand 1, 1 = pc_val_d1_i.
REQ-016 x_op2_sel_i  in  1  0 = register operand 2, 1 = imm_signed_i.
REQ-017 alu_sel_i  in  3  X-stage result select: 0 arith, 1 logic, 2 shift, 3 x_op1, 4 pc_d2, 5 pc_d2+PC_INC, 6-7 zero.
REQ-018 arith_out_i / logical_out_i / shift_out_i  in  XLEN each  external ALU unit results.
REQ-019 x_op1_o / x_op2_o  out  XLEN each  registered X-stage operands.
REQ-020 x_valid_o  out  1  X stage holds a valid instruction.
REQ-021 m_alu_data_o  out  XLEN  registered M-stage result.
REQ-022 w_data_o  out  XLEN  registered W-stage writeback data.
REQ-023 w_rd_addr_o  out  5  W-stage destination index.
REQ-024 w_we_o  out  1  register-file write strobe: W valid AND W we AND rd != 0.

Function
REQ-025 Pipeline D->X->M->W SHALL carry per-stage valid, rd and we; the result SHALL reach w_data_o 3 cycles after D acceptance with no stall.
REQ-026 Register operand source SHALL follow this priority: M stage (valid, we, rd != 0, rd == rs) gives m_alu_data_o; otherwise W stage under the same condition gives w_data_o; otherwise the register-file data. Index 0 SHALL never forward.
REQ-027 Operand muxes SHALL apply x_op1_sel_i / x_op2_sel_i after forwarding. rs1 SHALL be checked only when x_op1_sel_i = 0, and rs2 only when x_op2_sel_i = 0.
REQ-028 hazard = d_valid_i AND X valid AND X we AND X rd != 0 AND X rd equals a checked rs.
REQ-029 d_ready_o SHALL equal d_valid_i AND NOT stall_i AND NOT hazard AND NOT flush_i.
REQ-030 On hazard without stall_i: X SHALL load a bubble (valid 0), and M and W SHALL advance.
REQ-031 On stall_i without flush_i: every stage register SHALL hold its value.
REQ-032 On flush_i: next X valid = 0 and next M valid = 0, W SHALL take old M, and flush_i SHALL override stall_i and hazard.
REQ-033 M result SHALL be selected by alu_sel_i per REQ-017. Addition SHALL wrap modulo 2^XLEN, and a bubble SHALL still capture data with valid 0.
REQ-034 Simultaneous writeback to and read of the same index SHALL be resolved by W forwarding, never by register-file timing.

Reset
REQ-035 While rst_i is high at a clock edge, all valids, x_op1_o, x_op2_o, m_alu_data_o, w_data_o and w_rd_addr_o SHALL become 0, making w_we_o = 0 and d_ready_o = 0 until the first cycle with rst_i low. Reset SHALL override stall_i and flush_i.

Configuration
REQ-036 Macro FWD_DATAPATH_BYPASS_EN: when defined, forwarding SHALL follow REQ-026.
REQ-037 When FWD_DATAPATH_BYPASS_EN is undefined, operands SHALL come only from the register file, and hazard SHALL also assert on any checked rs matching a valid writing M or W rd != 0.

Verification
REQ-038 Add r1 <- 5, then immediately add r2 <- r1 + 3 (XLEN = 32) -> one bubble on x_valid_o, then x_op1_o = 5 via M forward, and w_data_o for r2 = 8.
REQ-039 Writer of r3 = 0x10 followed by reader of r3 two slots later -> no bubble, x_op1_o = 0x10 from W forward, with reg1_data_i = 0xDEAD ignored.
REQ-040 Writer with rd = 0 and data 0x55, then reader of r0 with reg1_data_i = 0 -> no hazard, x_op1_o = 0, w_we_o = 0.
REQ-041 stall_i high for 3 cycles mid-stream -> x_op1_o, m_alu_data_o and w_data_o unchanged for 3 cycles; flush_i raised with stall_i -> x_valid_o = 0 next cycle.
REQ-042 alu_sel_i = 5 with pc_val_d2_i = 0xFFFFFFFC -> m_alu_data_o = 0x00000000; rst_i asserted mid-stream -> all outputs 0 on the next edge.
REQ-043 Without FWD_DATAPATH_BYPASS_EN, rerunning the REQ-038 stimulus -> 3 bubbles, and x_op1_o is taken from reg1_data_i.
